// File: rtl/uart_rx_frame.sv
// 16x-oversampling UART receiver with a single-entry holding register, error flags and overrun.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting per bit; otherwise one centre sample is used.
module uart_rx_frame #(
  parameter int DIVISOR    = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  rxd_i,
  input  logic [1:0]            wls,
  input  logic                  parity_en,
  input  logic                  eps,
  input  logic                  sticky_parity,
  input  logic                  stop_bit,
  input  logic                  rx_rd_en,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_ready,
  output logic                  rx_done,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rxs_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            os_q, os_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  perr_q, perr_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  pe_q, pe_d;
  logic                  fe_q, fe_d;
  logic                  ovr_q, ovr_d;

  logic       tick, decide, smp, complete, stop_smp, exp_par;
  logic [3:0] dec_ph;
  logic [2:0] last_idx;
  logic       unused_stop_bit;

  // A second stop bit simply reads as idle line, so its setting is not needed here.
  assign unused_stop_bit = stop_bit;

  assign tick     = (cnt_q == CW'(DIVISOR - 1));
  assign cnt_d    = tick ? '0 : cnt_q + CW'(1);
  assign last_idx = {1'b0, wls} + 3'd4;
  assign exp_par  = sticky_parity ? ~eps : (eps ? ^sh_q : ~^sh_q);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  assign hist_d = tick ? {hist_q[0], rxs_q} : hist_q;
  assign smp    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
  // Stop bit votes one tick early so completion latency matches the single-sample build.
  assign dec_ph = (state_q == S_STOP) ? 4'd7 : 4'd8;
`else
  assign smp    = rxs_q;
  assign dec_ph = 4'd7;
`endif

  assign decide = tick && (os_q == dec_ph);

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    armed_d  = armed_q;
    complete = 1'b0;
    stop_smp = 1'b1;
    if (state_q != S_IDLE && tick) os_d = os_q + 4'd1;
    unique case (state_q)
      S_IDLE: begin
        os_d = 4'd0;
        if (rxs_q) armed_d = 1'b1;
        if (tick && armed_q && !rxs_q) begin
          state_d = S_START;
          sh_d    = '0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide) begin
          state_d = smp ? S_IDLE : S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) begin
          sh_d[idx_q] = smp;
          if (idx_q == last_idx) state_d = parity_en ? S_PARITY : S_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (decide) begin
          perr_d  = smp ^ exp_par;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          complete = 1'b1;
          stop_smp = smp;
          // A low stop bit may be a break: wait for the line to return high before re-arming.
          armed_d  = smp;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = ovr_q;
    done_d  = complete;
    if (rx_rd_en && ready_q) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end
    // A read in the same cycle frees the slot before the new byte is considered.
    if (complete) begin
      if (!ready_q || rx_rd_en) begin
        data_d  = sh_q;
        pe_d    = parity_en & perr_q;
        fe_d    = ~stop_smp;
        ready_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      cnt_q   <= '0;
      os_q    <= 4'd0;
      idx_q   <= 3'd0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      armed_q <= 1'b1;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q  <= 2'b11;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
      cnt_q   <= cnt_d;
      os_q    <= os_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign rx_data_o    = data_q;
  assign rx_ready     = ready_q;
  assign rx_done      = done_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame at DIVISOR=4 (64 clocks per bit).
module tb_uart_rx_frame;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       parity_en = 1'b0, eps = 1'b0, sticky = 1'b0, stop2 = 1'b0, rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, rx_done, pe, fe, ovr;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;
  int base;

  uart_rx_frame #(.DIVISOR(4), .DATA_WIDTH(8)) dut (
    .sys_clk(clk), .reset(rst_n), .rxd_i(rxd), .wls(wls), .parity_en(parity_en),
    .eps(eps), .sticky_parity(sticky), .stop_bit(stop2), .rx_rd_en(rd),
    .rx_data_o(rx_data), .rx_ready(rx_ready), .rx_done(rx_done),
    .parity_error(pe), .frame_error(fe), .overrun(ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_done) done_cnt <= done_cnt + 1;

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (has_par) send_bit(p);
    send_bit(s);
    rxd = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rx_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", rx_ready); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else passed++;
    total++; if ({rx_done, pe, fe, ovr} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {rx_done, pe, fe, ovr}); else passed++;
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic test_8n1();
    base = done_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (done_cnt !== base + 1) $display("FAIL 8n1_done got=%0d exp=%0d", done_cnt, base + 1); else passed++;
    total++; if (rx_data !== 8'hA5) $display("FAIL 8n1_data got=%h exp=a5", rx_data); else passed++;
    total++; if ({rx_ready, pe, fe} !== 3'b100) $display("FAIL 8n1_flags got=%b exp=100", {rx_ready, pe, fe}); else passed++;
  endtask

  task automatic test_parity_even();
    parity_en = 1'b1; eps = 1'b1;
    do_read();
    send_frame(8'hA6, 8, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    total++; if ({rx_data, pe, fe} !== {8'hA6, 2'b00}) $display("FAIL par_ok got=%h/%b%b exp=a6/00", rx_data, pe, fe); else passed++;
    do_read();
    send_frame(8'hA7, 8, 1'b1, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    total++; if ({rx_data, pe, fe} !== {8'hA7, 2'b10}) $display("FAIL par_bad got=%h/%b%b exp=a7/10", rx_data, pe, fe); else passed++;
  endtask

  task automatic test_sticky5();
    wls = 2'b00; sticky = 1'b1; eps = 1'b0; parity_en = 1'b1;
    do_read();
    send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (rx_data !== 8'h15) $display("FAIL sticky_data got=%h exp=15", rx_data); else passed++;
    total++; if ({rx_ready, pe} !== 2'b10) $display("FAIL sticky_flags got=%b exp=10", {rx_ready, pe}); else passed++;
    wls = 2'b11; sticky = 1'b0; parity_en = 1'b0;
  endtask

  task automatic test_frame_error();
    do_read();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    total++; if ({rx_data, fe} !== {8'h3C, 1'b1}) $display("FAIL ferr got=%h/%b exp=3c/1", rx_data, fe); else passed++;
  endtask

  task automatic test_back_to_back();
    do_read();
    base = done_cnt;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    total++; if ({rx_ready, ovr, rx_data} !== {2'b10, 8'h11}) $display("FAIL b2b_f1 got=%b%b/%h exp=10/11", rx_ready, ovr, rx_data); else passed++;
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    total++; if ({ovr, rx_data} !== {1'b1, 8'h11}) $display("FAIL b2b_f2 got=%b/%h exp=1/11", ovr, rx_data); else passed++;
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (done_cnt !== base + 3) $display("FAIL b2b_done got=%0d exp=%0d", done_cnt, base + 3); else passed++;
    total++; if ({ovr, fe, rx_data} !== {2'b10, 8'h11}) $display("FAIL b2b_f3 got=%b%b/%h exp=10/11", ovr, fe, rx_data); else passed++;
    do_read();
    total++; if ({rx_ready, ovr, rx_data} !== {2'b00, 8'h11}) $display("FAIL b2b_read got=%b%b/%h exp=00/11", rx_ready, ovr, rx_data); else passed++;
  endtask

  task automatic test_glitch();
    base = done_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    total++; if ({done_cnt, rx_ready} !== {base, 1'b0}) $display("FAIL glitch got=%0d/%b exp=%0d/0", done_cnt, rx_ready, base); else passed++;
  endtask

  task automatic test_break();
    base = done_cnt;
    rxd = 1'b0;
    repeat (11 * BIT) @(negedge clk);
    total++; if ({rx_data, fe, rx_ready} !== {8'h00, 2'b11}) $display("FAIL break_data got=%h/%b%b exp=00/11", rx_data, fe, rx_ready); else passed++;
    repeat (10 * BIT) @(negedge clk);
    total++; if (done_cnt !== base + 1) $display("FAIL break_rearm got=%0d exp=%0d", done_cnt, base + 1); else passed++;
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({rx_ready, rx_data, fe, pe, ovr} !== 12'h0) $display("FAIL midrst got=%b/%h/%b%b%b exp=0/00/000", rx_ready, rx_data, fe, pe, ovr); else passed++;
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    base = done_cnt;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (done_cnt !== base + 1) $display("FAIL post_rst_done got=%0d exp=%0d", done_cnt, base + 1); else passed++;
    total++; if ({rx_ready, rx_data, fe, pe} !== {1'b1, 8'h5A, 2'b00}) $display("FAIL post_rst_data got=%b/%h/%b%b exp=1/5a/00", rx_ready, rx_data, fe, pe); else passed++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_even();
    test_sticky5();
    test_frame_error();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
